// File: rtl/tb_min_search_pkg.sv
// tb_min_search_pkg
//   Shared definitions for the minimum-metric search block: FSM state
//   encoding, default parameter values and a constant log2 helper.
//   No ports.
package tb_min_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_W     = 8;
  localparam int DEF_M     = 3;
  localparam int DEF_LANES = 2;

  // Ceiling log2 for elaboration-time constants; log2_c(1) = 0.
  function automatic int log2_c(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/tb_min_search_lane_min.sv
// tb_lane_min
//   Combinational reduction of LANES unsigned metrics to the smallest
//   value and its lane index. Ties resolve to the lowest lane index.
//   Depth is log2(LANES) compare levels (pairwise tree).
// Ports:
//   vals      in  LANES*W  lane l occupies bits [l*W +: W]
//   lane_min  out W        smallest metric
//   lane_idx  out IW       lane index of the smallest metric
module tb_lane_min #(
  parameter int W     = 8,
  parameter int LANES = 2,
  parameter int IW    = 1
) (
  input  logic [LANES*W-1:0] vals,
  output logic [W-1:0]       lane_min,
  output logic [IW-1:0]      lane_idx
);

  logic [W-1:0]  m  [LANES];
  logic [IW-1:0] ix [LANES];

  // Pairwise tree: at each level slot i absorbs slot i+step. The lower
  // slot is kept unless the upper one is strictly smaller, which keeps
  // the lowest index on ties.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      m[i]  = vals[i*W +: W];
      ix[i] = IW'(i);
    end
    for (int step = 1; step < LANES; step = step * 2) begin
      for (int i = 0; i < LANES; i = i + 2 * step) begin
        if (m[i+step] < m[i]) begin
          m[i]  = m[i+step];
          ix[i] = ix[i+step];
        end
      end
    end
    lane_min = m[0];
    lane_idx = ix[0];
  end

endmodule

// File: rtl/tb_min_search.sv
// tb_min_search
//   Multi-cycle minimum path-metric search for a Viterbi traceback
//   controller. Scans LANES states per clock over N = 2^M states and
//   returns the lowest-index state holding the minimum metric.
//   Optional feature macro: TB_NORM_EN (renormalisation request).
// Ports:
//   clk         in  1    rising-edge clock
//   reset       in  1    synchronous, active-high
//   in_valid    in  1    metric vector offered
//   in_ready    out 1    vector can be accepted
//   metrics     in  N*W  state s at bits [s*W +: W]
//   out_valid   out 1    result held
//   out_ready   in  1    consumer takes result
//   min_state   out M    index of the minimum-metric state
//   min_metric  out W    the minimum metric
//   norm_req    out 1    minimum MSB set (TB_NORM_EN only, else 0)
//
// state | meaning
// IDLE  | waiting for a vector, in_ready high
// SCAN  | reducing one LANES-wide chunk per cycle into the running best
// DONE  | result held on out_valid until out_ready
module tb_min_search
  import tb_min_search_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int M     = DEF_M,
  parameter int LANES = DEF_LANES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [(1<<M)*W-1:0]    metrics,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M-1:0]           min_state,
  output logic [W-1:0]           min_metric,
  output logic                   norm_req
);

  localparam int N  = 1 << M;
  localparam int LB = log2_c(LANES);
  localparam int S  = N / LANES;
  localparam int CW = (M - LB) > 0 ? (M - LB) : 1;
  localparam int IW = LB > 0 ? LB : 1;

  if (LANES < 1 || LANES > N || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("tb_min_search: LANES must be a power of two in 1..2^M");
  end

  state_t          state;
  logic [N*W-1:0]  metrics_q;
  logic [CW-1:0]   chunk;
  logic [W-1:0]    best_metric;
  logic [M-1:0]    best_idx;
  logic            out_valid_q;

  logic [W-1:0]    lane_min;
  logic [IW-1:0]   lane_idx;
  logic            take;
  logic [W-1:0]    nxt_metric;
  logic [M-1:0]    nxt_idx;

  tb_lane_min #(.W(W), .LANES(LANES), .IW(IW)) u_lane_min (
    .vals     (metrics_q[int'(chunk)*LANES*W +: LANES*W]),
    .lane_min (lane_min),
    .lane_idx (lane_idx)
  );

  // Chunk 0 seeds the running best unconditionally; later chunks replace
  // it only on strict less-than so earlier (lower) states win ties.
  always_comb begin
    take       = (chunk == '0) || (lane_min < best_metric);
    nxt_metric = take ? lane_min : best_metric;
    nxt_idx    = take ? M'(int'(chunk) * LANES + int'(lane_idx)) : best_idx;
  end

  assign in_ready   = !reset && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign out_valid  = out_valid_q;
  assign min_state  = best_idx;
  assign min_metric = best_metric;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      metrics_q   <= '0;
      chunk       <= '0;
      best_metric <= '0;
      best_idx    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            metrics_q <= metrics;
            chunk     <= '0;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          best_metric <= nxt_metric;
          best_idx    <= nxt_idx;
          if (chunk == CW'(S - 1)) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            chunk <= chunk + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              metrics_q <= metrics;
              chunk     <= '0;
              state     <= ST_SCAN;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef TB_NORM_EN
  logic norm_q;

  // Registered on the edge entering DONE from the final running best,
  // so it lines up with min_metric and holds with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      norm_q <= 1'b0;
    end else if (state == ST_SCAN && chunk == CW'(S - 1)) begin
      norm_q <= nxt_metric[W-1];
    end else if (state == ST_DONE && out_ready) begin
      norm_q <= 1'b0;
    end
  end

  assign norm_req = norm_q;
`else
  assign norm_req = 1'b0;
`endif

endmodule

// File: tb/tb_tb_min_search.sv
// Self-checking bench for tb_min_search: default instance plus LANES=8
// and LANES=1 instances, randomized vectors against a reference model.
module tb_tb_min_search;

  localparam int W = 8;
  localparam int M = 3;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N*W-1:0] metrics;

  logic           in_valid, in_ready, out_valid, out_ready, norm_req;
  logic [M-1:0]   min_state;
  logic [W-1:0]   min_metric;

  logic           iv8, ir8, ov8, nr8;
  logic [M-1:0]   ms8;
  logic [W-1:0]   mm8;
  logic           iv1, ir1, ov1, nr1;
  logic [M-1:0]   ms1;
  logic [W-1:0]   mm1;

  int checks = 0;
  int errors = 0;

  tb_min_search #(.W(W), .M(M), .LANES(2)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .metrics(metrics), .out_valid(out_valid), .out_ready(out_ready),
    .min_state(min_state), .min_metric(min_metric), .norm_req(norm_req)
  );

  tb_min_search #(.W(W), .M(M), .LANES(8)) u_l8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .metrics(metrics), .out_valid(ov8), .out_ready(1'b1),
    .min_state(ms8), .min_metric(mm8), .norm_req(nr8)
  );

  tb_min_search #(.W(W), .M(M), .LANES(1)) u_l1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
    .metrics(metrics), .out_valid(ov1), .out_ready(1'b1),
    .min_state(ms1), .min_metric(mm1), .norm_req(nr1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the minimum value, then the first state that holds it.
  function automatic void ref_min(input logic [7:0] v[8], output int st, output int mn);
    mn = v[0];
    foreach (v[i]) if (v[i] < mn) mn = v[i];
    st = -1;
    foreach (v[i]) if (st < 0 && v[i] == mn) st = i;
  endfunction

  function automatic int ref_norm(input int mn);
`ifdef TB_NORM_EN
    return (mn >= 128) ? 1 : 0;
`else
    return (mn < 0) ? 1 : 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input logic [7:0] v[8]);
    for (int i = 0; i < N; i++) metrics[i*W +: W] = v[i];
  endtask

  // Waits for out_valid on the default DUT; returns edges counted.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] v[8]);
    int st, mn;
    ref_min(v, st, mn);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_state"}, min_state, st);
    check({tag, "_metric"}, min_metric, mn);
    check({tag, "_norm"}, norm_req, ref_norm(mn));
  endtask

  // Accept v (DUT must be IDLE), hold out_ready low for `hold` cycles in
  // DONE checking stability, then consume the result.
  task automatic do_vec(input string tag, input logic [7:0] v[8], input int hold);
    int cyc;
    int st, mn;
    ref_min(v, st, mn);
    drive_vec(v);
    in_valid = 1'b1;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    metrics  = {$urandom, $urandom};
    check({tag, "_in_ready_scan"}, in_ready, 0);
    wait_result(cyc);
    check({tag, "_latency"}, cyc, 4);
    check_result(tag, v);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_state"}, min_state, st);
      check({tag, "_hold_metric"}, min_metric, mn);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_consumed"}, out_valid, 0);
  endtask

  task automatic run_alt(input string tag, input int which, input logic [7:0] v[8], input int lat);
    int cyc, st, mn;
    logic ov;
    ref_min(v, st, mn);
    drive_vec(v);
    if (which == 8) iv8 = 1'b1; else iv1 = 1'b1;
    tick();
    iv8 = 1'b0;
    iv1 = 1'b0;
    metrics = {$urandom, $urandom};
    cyc = 0;
    ov  = (which == 8) ? ov8 : ov1;
    while (!ov && cyc < 20) begin
      tick();
      cyc++;
      ov = (which == 8) ? ov8 : ov1;
    end
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_state"}, (which == 8) ? ms8 : ms1, st);
    check({tag, "_metric"}, (which == 8) ? mm8 : mm1, mn);
    tick();
  endtask

  logic [7:0] v[8];
  logic [7:0] v2[8];
  int cyc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; iv8 = 1'b0; iv1 = 1'b0;
    metrics = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_min_state", min_state, 0);
    check("rst_min_metric", min_metric, 0);
    check("rst_norm", norm_req, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    v = '{9, 7, 3, 12, 3, 15, 8, 10};
    do_vec("dir_tie", v, 0);
    v = '{5, 5, 5, 5, 5, 5, 5, 5};
    do_vec("dir_equal", v, 1);

    // Stall in DONE, then handshake and accept a new vector on one edge.
    v = '{40, 33, 90, 33, 70, 20, 21, 20};
    do_vec("stall_pre", v, 0);
    drive_vec(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(cyc);
    check("stall_latency", cyc, 4);
    for (int h = 0; h < 3; h++) begin
      tick();
      check("stall_state", min_state, 5);
      check("stall_metric", min_metric, 20);
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
    end
    v2 = '{1, 0, 6, 6, 6, 6, 6, 6};
    drive_vec(v2);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    check("b2b_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_handoff_valid", out_valid, 0);
    wait_result(cyc);
    check("b2b_latency", cyc, 4);
    check_result("b2b", v2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the second SCAN cycle discards the vector.
    v = '{50, 60, 1, 2, 3, 4, 5, 6};
    drive_vec(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_result", out_valid, 0);
    end
    v = '{77, 66, 55, 44, 33, 22, 11, 99};
    do_vec("after_rst", v, 0);

    v = '{200, 140, 130, 255, 131, 180, 130, 250};
    do_vec("norm_130", v, 1);
    v = '{200, 140, 127, 255, 131, 180, 128, 250};
    do_vec("norm_127", v, 0);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++)
        v[i] = (t % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      do_vec("rand", v, $urandom_range(0, 2));
    end

    v = '{200, 200, 200, 200, 200, 200, 200, 0};
    run_alt("l8_dir", 8, v, 1);
    v = '{5, 5, 5, 5, 5, 5, 5, 5};
    run_alt("l1_equal", 1, v, 8);
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) v[i] = 8'($urandom_range(0, 15));
      run_alt("l8_rand", 8, v, 1);
      run_alt("l1_rand", 1, v, 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
